// File: rtl/histogram_sram_hakem.sv
// Phase sequencer and single-port arbiter for the shared histogram SRAM (HB, HE, host readout).
// Define HISTOGRAM_TEMIZLE_EN to build the pre-frame SRAM clear phase (TEMIZLE).
module histogram_sram_hakem #(
   parameter int PIXEL_BIT = 8,
   parameter int VERI_BIT  = 17
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 etkin_i,
   input  logic                 stal_i,
   input  logic                 hb_bitti_i,
   input  logic                 he_bitti_i,
   input  logic                 hb_wr_i,
   input  logic                 hb_rd_i,
   input  logic [PIXEL_BIT-1:0] hb_waddr_i,
   input  logic [PIXEL_BIT-1:0] hb_raddr_i,
   input  logic [VERI_BIT-1:0]  hb_wdata_i,
   input  logic                 he_wr_i,
   input  logic                 he_rd_i,
   input  logic [PIXEL_BIT-1:0] he_waddr_i,
   input  logic [PIXEL_BIT-1:0] he_raddr_i,
   input  logic [VERI_BIT-1:0]  he_wdata_i,
   input  logic                 host_req_i,
   input  logic [PIXEL_BIT-1:0] host_raddr_i,
   output logic                 host_gnt_o,
   output logic                 wr_en_s_o,
   output logic [PIXEL_BIT-1:0] addr_w_s_o,
   output logic [VERI_BIT-1:0]  data_in_s_o,
   output logic                 rd_en_s_o,
   output logic [PIXEL_BIT-1:0] addr_r_s_o,
   input  logic [VERI_BIT-1:0]  data_out_s_i,
   output logic [VERI_BIT-1:0]  rd_veri_o,
   output logic                 hb_rvalid_o,
   output logic                 he_rvalid_o,
   output logic                 host_rvalid_o,
   output logic [2:0]           faz_o,
   output logic                 hazir_o
);

   typedef enum logic [2:0] {BEKLE = 3'd0, TEMIZLE = 3'd1, HB = 3'd2, HE = 3'd3} faz_t;
   typedef enum logic [1:0] {TAG_YOK = 2'd0, TAG_HB = 2'd1, TAG_HE = 2'd2, TAG_HOST = 2'd3} tag_t;

   typedef struct packed {
      logic                 wr_en;
      logic [PIXEL_BIT-1:0] addr_w;
      logic [VERI_BIT-1:0]  data_in;
      logic                 rd_en;
      logic [PIXEL_BIT-1:0] addr_r;
   } cmd_t;

   localparam cmd_t CMD_IDLE = {1'b1, {PIXEL_BIT{1'b0}}, {VERI_BIT{1'b0}}, 1'b1, {PIXEL_BIT{1'b0}}};

   faz_t faz_q, faz_d;
   tag_t tag_q, tag_d;
   cmd_t cmd_q, cmd_d, cmd_s;
   logic hazir_q, hazir_d;
   logic host_gnt;
`ifdef HISTOGRAM_TEMIZLE_EN
   logic [PIXEL_BIT-1:0] cnt_q, cnt_d;
`endif

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      faz_d    = faz_q;
      tag_d    = TAG_YOK;
      cmd_d    = CMD_IDLE;
      hazir_d  = 1'b0;
      host_gnt = 1'b0;
`ifdef HISTOGRAM_TEMIZLE_EN
      cnt_d    = cnt_q;
`endif
      case (faz_q)
         BEKLE: begin
            host_gnt = host_req_i;
            if (host_req_i) begin
               cmd_d.rd_en  = 1'b0;
               cmd_d.addr_r = host_raddr_i;
               tag_d        = TAG_HOST;
            end
`ifdef HISTOGRAM_TEMIZLE_EN
            if (etkin_i) faz_d = TEMIZLE;
`else
            if (etkin_i) faz_d = HB;
`endif
         end
`ifdef HISTOGRAM_TEMIZLE_EN
         TEMIZLE: begin
            cmd_d.wr_en  = 1'b0;
            cmd_d.addr_w = cnt_q;
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == '1) faz_d = HB;
         end
`endif
         HB: begin
            if (hb_wr_i) begin
               cmd_d.wr_en   = 1'b0;
               cmd_d.addr_w  = hb_waddr_i;
               cmd_d.data_in = hb_wdata_i;
            end
            if (hb_rd_i) begin
               cmd_d.rd_en  = 1'b0;
               cmd_d.addr_r = hb_raddr_i;
               tag_d        = TAG_HB;
            end
            if (hb_bitti_i) faz_d = HE;
         end
         HE: begin
            if (he_wr_i) begin
               cmd_d.wr_en   = 1'b0;
               cmd_d.addr_w  = he_waddr_i;
               cmd_d.data_in = he_wdata_i;
            end
            if (he_rd_i) begin
               cmd_d.rd_en  = 1'b0;
               cmd_d.addr_r = he_raddr_i;
               tag_d        = TAG_HE;
            end
            if (he_bitti_i) begin
               faz_d   = BEKLE;
               hazir_d = 1'b1;
            end
         end
         default: faz_d = BEKLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state is updated with non-blocking assignments only, so every register samples pre-edge values.
      if (rst_i) begin
         faz_q   <= BEKLE;
         tag_q   <= TAG_YOK;
         cmd_q   <= CMD_IDLE;
         hazir_q <= 1'b0;
`ifdef HISTOGRAM_TEMIZLE_EN
         cnt_q   <= '0;
`endif
      end else if (!stal_i) begin
         faz_q   <= faz_d;
         tag_q   <= tag_d;
         cmd_q   <= cmd_d;
         hazir_q <= hazir_d;
`ifdef HISTOGRAM_TEMIZLE_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // While stalled the SRAM sees the last command that was actually issued.
   assign cmd_s         = stal_i ? cmd_q : cmd_d;
   assign wr_en_s_o     = cmd_s.wr_en;
   assign addr_w_s_o    = cmd_s.addr_w;
   assign data_in_s_o   = cmd_s.data_in;
   assign rd_en_s_o     = cmd_s.rd_en;
   assign addr_r_s_o    = cmd_s.addr_r;

   assign host_gnt_o    = host_gnt & ~stal_i;
   assign rd_veri_o     = data_out_s_i;
   assign hb_rvalid_o   = (tag_q == TAG_HB);
   assign he_rvalid_o   = (tag_q == TAG_HE);
   assign host_rvalid_o = (tag_q == TAG_HOST);
   assign faz_o         = faz_q;
   assign hazir_o       = hazir_q;

endmodule

// File: tb/tb_histogram_sram_hakem.sv
// Scoreboard bench for histogram_sram_hakem with a behavioural SRAM model.
// Exercises the clear phase when HISTOGRAM_TEMIZLE_EN is defined, the direct BEKLE->HB path otherwise.
module tb_histogram_sram_hakem;

   localparam int PB    = 8;
   localparam int VB    = 17;
   localparam int DEPTH = 1 << PB;

   localparam logic [2:0] W_HB   = 3'b100;
   localparam logic [2:0] W_HE   = 3'b010;
   localparam logic [2:0] W_HOST = 3'b001;

   typedef struct packed {
      logic [2:0]    who;
      logic [VB-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_i, etkin_i, stal_i, hb_bitti_i, he_bitti_i;
   logic          hb_wr_i, hb_rd_i, he_wr_i, he_rd_i, host_req_i;
   logic [PB-1:0] hb_waddr_i, hb_raddr_i, he_waddr_i, he_raddr_i, host_raddr_i;
   logic [VB-1:0] hb_wdata_i, he_wdata_i;
   logic          host_gnt_o, wr_en_s_o, rd_en_s_o;
   logic [PB-1:0] addr_w_s_o, addr_r_s_o;
   logic [VB-1:0] data_in_s_o, rd_veri_o;
   logic [VB-1:0] data_out_s_i = '0;
   logic          hb_rvalid_o, he_rvalid_o, host_rvalid_o, hazir_o;
   logic [2:0]    faz_o;

   logic [VB-1:0] mem     [DEPTH];
   logic [VB-1:0] exp_mem [DEPTH];
   exp_t          sb [$];
   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc_cnt = 0;
   int            t0;

   always #5 clk = ~clk;

   histogram_sram_hakem #(.PIXEL_BIT(PB), .VERI_BIT(VB)) dut (
      .clk_i(clk), .rst_i(rst_i), .etkin_i(etkin_i), .stal_i(stal_i),
      .hb_bitti_i(hb_bitti_i), .he_bitti_i(he_bitti_i),
      .hb_wr_i(hb_wr_i), .hb_rd_i(hb_rd_i), .hb_waddr_i(hb_waddr_i),
      .hb_raddr_i(hb_raddr_i), .hb_wdata_i(hb_wdata_i),
      .he_wr_i(he_wr_i), .he_rd_i(he_rd_i), .he_waddr_i(he_waddr_i),
      .he_raddr_i(he_raddr_i), .he_wdata_i(he_wdata_i),
      .host_req_i(host_req_i), .host_raddr_i(host_raddr_i), .host_gnt_o(host_gnt_o),
      .wr_en_s_o(wr_en_s_o), .addr_w_s_o(addr_w_s_o), .data_in_s_o(data_in_s_o),
      .rd_en_s_o(rd_en_s_o), .addr_r_s_o(addr_r_s_o), .data_out_s_i(data_out_s_i),
      .rd_veri_o(rd_veri_o), .hb_rvalid_o(hb_rvalid_o), .he_rvalid_o(he_rvalid_o),
      .host_rvalid_o(host_rvalid_o), .faz_o(faz_o), .hazir_o(hazir_o)
   );

   // Behavioural SRAM: active-low enables, one-cycle read latency.
   always @(posedge clk) begin
      if (!wr_en_s_o) mem[addr_w_s_o] <= data_in_s_o;
      if (!rd_en_s_o) data_out_s_i <= mem[addr_r_s_o];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic sb_push(input logic [2:0] w, input logic [VB-1:0] d);
      exp_t e;
      e.who  = w;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic idle();
      etkin_i = 0; hb_bitti_i = 0; he_bitti_i = 0;
      hb_wr_i = 0; hb_rd_i = 0; he_wr_i = 0; he_rd_i = 0; host_req_i = 0;
      hb_waddr_i = '0; hb_raddr_i = '0; he_waddr_i = '0; he_raddr_i = '0;
      hb_wdata_i = '0; he_wdata_i = '0; host_raddr_i = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_cnt++;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Read returns: one entry popped per non-stalled cycle with any rvalid high.
   logic [2:0] rv_now;
   exp_t       rv_exp;
   always @(negedge clk) begin
      if (!rst_i && !stal_i) begin
         rv_now = {hb_rvalid_o, he_rvalid_o, host_rvalid_o};
         if (rv_now != 3'b000) begin
            if (sb.size() == 0) begin
               check("rv_unexpected", 64'(rv_now), 64'd0);
            end else begin
               rv_exp = sb.pop_front();
               check("rv_owner", 64'(rv_now), 64'(rv_exp.who));
               check("rv_data", 64'(rd_veri_o), 64'(rv_exp.data));
            end
         end
      end
   end

`ifdef HISTOGRAM_TEMIZLE_EN
   // Entered in the first TEMIZLE cycle; leaves in the first HB cycle unless reset is hit.
   task automatic do_clear(input int stall_at, input int rst_at);
      for (int k = 0; k < DEPTH; k++) begin
         settle();
         check("clr", 64'({faz_o, wr_en_s_o, addr_w_s_o, data_in_s_o, rd_en_s_o}),
               64'({3'd1, 1'b0, 8'(k), 17'd0, 1'b1}));
         if (k == rst_at) begin
            rst_i = 1;
            cyc();
            rst_i = 0;
            return;
         end
         cyc();
         if (k == stall_at) begin
            stal_i = 1;
            for (int s = 0; s < 3; s++) begin
               settle();
               check("stall_pins", 64'({faz_o, wr_en_s_o, addr_w_s_o, data_in_s_o}),
                     64'({3'd1, 1'b0, 8'(k), 17'd0}));
               cyc();
            end
            stal_i = 0;
         end
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = VB'(i * 3 + 100);
         exp_mem[i] = VB'(i * 3 + 100);
      end
      rst_i = 1; stal_i = 0;
      idle();
      repeat (3) cyc();
      rst_i = 0;
      settle();
      check("rst_faz", 64'(faz_o), 64'd0);
      check("rst_cmd", 64'({wr_en_s_o, addr_w_s_o, data_in_s_o, rd_en_s_o, addr_r_s_o}),
            64'({1'b1, 8'd0, 17'd0, 1'b1, 8'd0}));
      check("rst_rvalid", 64'({hb_rvalid_o, he_rvalid_o, host_rvalid_o}), 64'd0);
      check("rst_gnt", 64'(host_gnt_o), 64'd0);
      check("rst_hazir", 64'(hazir_o), 64'd0);

      // Host read in BEKLE, then a stall that must hold the command and swallow etkin_i
      cyc(); host_req_i = 1; host_raddr_i = 8'h07;
      settle();
      check("host_gnt", 64'(host_gnt_o), 64'd1);
      check("host_rd_pin", 64'({rd_en_s_o, addr_r_s_o}), 64'({1'b0, 8'h07}));
      sb_push(W_HOST, exp_mem[8'h07]);
      cyc(); host_raddr_i = 8'h09; stal_i = 1; etkin_i = 1;
      settle();
      check("stall_gnt", 64'(host_gnt_o), 64'd0);
      check("stall_rd_hold", 64'({rd_en_s_o, addr_r_s_o}), 64'({1'b0, 8'h07}));
      check("stall_rv_hold", 64'(host_rvalid_o), 64'd1);
      cyc(); settle();
      check("stall_faz", 64'(faz_o), 64'd0);
      cyc(); stal_i = 0; idle();
      settle();
      check("stall_faz_after", 64'(faz_o), 64'd0);

      // Frame start
      cyc(); etkin_i = 1; t0 = cyc_cnt;
      cyc(); idle();
`ifdef HISTOGRAM_TEMIZLE_EN
      do_clear(8'h80, -1);
      settle();
      check("clr_done_faz", 64'(faz_o), 64'd2);
      check("clr_len", 64'(cyc_cnt - t0), 64'd260);
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
`else
      settle();
      check("hb_entry_faz", 64'(faz_o), 64'd2);
      check("hb_entry_len", 64'(cyc_cnt - t0), 64'd1);
`endif
      check("hb_idle_pins", 64'({wr_en_s_o, addr_w_s_o, data_in_s_o, rd_en_s_o, addr_r_s_o}),
            64'({1'b1, 8'd0, 17'd0, 1'b1, 8'd0}));

      // HB owns both ports; HE and host requests and stray phase pulses are ignored
      cyc();
      hb_wr_i = 1; hb_waddr_i = 8'h12; hb_wdata_i = 17'h00005;
      he_wr_i = 1; he_waddr_i = 8'h34; he_wdata_i = 17'h1FFFF;
      hb_rd_i = 1; hb_raddr_i = 8'h12; he_rd_i = 1; he_raddr_i = 8'h20;
      host_req_i = 1; host_raddr_i = 8'h12; etkin_i = 1; he_bitti_i = 1;
      settle();
      check("hb_wr_pin", 64'({wr_en_s_o, addr_w_s_o, data_in_s_o}), 64'({1'b0, 8'h12, 17'h00005}));
      check("hb_rd_pin", 64'({rd_en_s_o, addr_r_s_o}), 64'({1'b0, 8'h12}));
      check("hb_host_gnt", 64'(host_gnt_o), 64'd0);
      sb_push(W_HB, exp_mem[8'h12]);
      exp_mem[8'h12] = 17'h00005;

      cyc(); idle(); hb_rd_i = 1; hb_raddr_i = 8'h12; hb_bitti_i = 1;
      settle();
      check("hb_ignored_evt", 64'(faz_o), 64'd2);
      sb_push(W_HB, exp_mem[8'h12]);

      cyc(); idle();
      he_wr_i = 1; he_waddr_i = 8'h40; he_wdata_i = 17'h1ABCD;
      hb_wr_i = 1; hb_waddr_i = 8'h41; hb_wdata_i = 17'h00007;
      host_req_i = 1; host_raddr_i = 8'h12;
      settle();
      check("he_faz", 64'(faz_o), 64'd3);
      check("he_wr_pin", 64'({wr_en_s_o, addr_w_s_o, data_in_s_o}), 64'({1'b0, 8'h40, 17'h1ABCD}));
      check("he_host_gnt", 64'(host_gnt_o), 64'd0);
      exp_mem[8'h40] = 17'h1ABCD;

      // HE read coinciding with he_bitti_i; hb_bitti_i is stray here
      cyc(); idle(); he_rd_i = 1; he_raddr_i = 8'h40; he_bitti_i = 1; hb_bitti_i = 1;
      settle();
      check("he_rd_pin", 64'({rd_en_s_o, addr_r_s_o}), 64'({1'b0, 8'h40}));
      check("he_last_faz", 64'(faz_o), 64'd3);
      check("he_hazir_early", 64'(hazir_o), 64'd0);
      sb_push(W_HE, exp_mem[8'h40]);

      cyc(); idle(); host_req_i = 1; host_raddr_i = 8'h12;
      settle();
      check("end_faz", 64'(faz_o), 64'd0);
      check("end_hazir", 64'(hazir_o), 64'd1);
      check("end_he_rvalid", 64'(he_rvalid_o), 64'd1);
      check("end_host_gnt", 64'(host_gnt_o), 64'd1);
      sb_push(W_HOST, exp_mem[8'h12]);

      cyc(); idle();
      settle();
      check("hazir_pulse", 64'(hazir_o), 64'd0);

      // Reset in the middle of a frame, then (with clear) a fresh clear from address 0
      cyc(); etkin_i = 1;
      cyc(); idle();
`ifdef HISTOGRAM_TEMIZLE_EN
      do_clear(-1, 8'h33);
      settle();
      check("rst_mid_faz", 64'(faz_o), 64'd0);
      check("rst_mid_en", 64'({wr_en_s_o, rd_en_s_o}), 64'(2'b11));
      cyc(); etkin_i = 1; t0 = cyc_cnt;
      cyc(); idle();
      do_clear(-1, -1);
      settle();
      check("clr2_faz", 64'(faz_o), 64'd2);
      check("clr2_len", 64'(cyc_cnt - t0), 64'd257);
      cyc(); hb_rd_i = 1; hb_raddr_i = 8'h12;
      settle();
      sb_push(W_HB, 17'd0);
      cyc(); idle();
      settle();
`else
      settle();
      check("hb2_faz", 64'(faz_o), 64'd2);
      hb_wr_i = 1; hb_waddr_i = 8'h55; hb_wdata_i = 17'h00009; hb_rd_i = 1; hb_raddr_i = 8'h55;
      exp_mem[8'h55] = 17'h00009;
      rst_i = 1;
      cyc(); rst_i = 0; idle();
      settle();
      check("rst_mid_faz", 64'(faz_o), 64'd0);
      check("rst_mid_en", 64'({wr_en_s_o, rd_en_s_o}), 64'(2'b11));
      check("rst_mid_rvalid", 64'({hb_rvalid_o, he_rvalid_o, host_rvalid_o}), 64'd0);
`endif
      cyc(); settle();
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
